// File: rtl/edc_scrubber_if.sv
// Wishbone initiator bus plus EDC corrector status lines shared by the scrubber and the EDC slave.
// Signal names follow the bus, not the direction; the modports give direction.
interface edc_scrubber_if #(
  parameter int unsigned WB_DWIDTH = 32,
  parameter int unsigned WB_SWIDTH = 4
) ();
  logic [31:0]          wb_adr;
  logic [WB_SWIDTH-1:0] wb_sel;
  logic                 wb_we;
  logic [WB_DWIDTH-1:0] wb_dat_w;
  logic [WB_DWIDTH-1:0] wb_dat_r;
  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_ack;
  logic                 wb_err;
  logic                 edc_single;
  logic                 edc_double;

  modport master (
    output wb_adr, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb,
    input  wb_dat_r, wb_ack, wb_err, edc_single, edc_double
  );

  modport slave (
    input  wb_adr, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb,
    output wb_dat_r, wb_ack, wb_err, edc_single, edc_double
  );
endinterface

// File: rtl/edc_scrubber.sv
// Background EDC memory scrubber: walks a word range over Wishbone, writes back corrected data on
// single-bit errors, and keeps saturating error counters plus the last failing address.
module edc_scrubber #(
  parameter int unsigned WB_DWIDTH   = 32,
  parameter int unsigned WB_SWIDTH   = 4,
  parameter logic [31:0] SCRUB_BASE  = 32'h0000_0000,
  parameter int unsigned SCRUB_WORDS = 1024,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_enable,
  edc_scrubber_if.master wb,
  output logic           o_busy,
  output logic [15:0]    o_corr_count,
  output logic [15:0]    o_uncorr_count,
  output logic [31:0]    o_fail_adr,
  output logic           o_pass_done
);

  localparam int unsigned   GapW    = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(IDLE_CYCLES);
  localparam logic [31:0]   LastAdr = SCRUB_BASE + 32'(4 * (SCRUB_WORDS - 1));

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StRead,
    StSpace,
    StWrite,
    StNext
  } state_e;

  state_e               state_q;
  logic [GapW-1:0]      gap_q;
  logic [31:0]          adr_q;
  logic [WB_DWIDTH-1:0] dat_q;
  logic [WB_SWIDTH-1:0] sel_q;
  logic                 cyc_q;
  logic                 stb_q;
  logic                 we_q;
  logic [15:0]          corr_cnt_q;
  logic [15:0]          uncorr_cnt_q;
  logic [31:0]          fail_adr_q;
  logic                 pass_done_q;
  logic                 busy_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      gap_q        <= '0;
      adr_q        <= SCRUB_BASE;
      dat_q        <= '0;
      sel_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      fail_adr_q   <= '0;
      pass_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_enable) begin
            gap_q   <= GapLoad;
            busy_q  <= 1'b1;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= '1;
            state_q <= StRead;
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end
        StRead: begin
          if (wb.wb_ack || wb.wb_err) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            sel_q <= '0;
            // A bus error or an uncorrectable word is never written back.
            if (wb.wb_err || wb.edc_double) begin
              uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
              fail_adr_q   <= adr_q;
              state_q      <= StNext;
            end else if (wb.edc_single) begin
              dat_q   <= wb.wb_dat_r;
              state_q <= StSpace;
            end else begin
              state_q <= StNext;
            end
          end
        end
        StSpace: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          sel_q   <= '1;
          state_q <= StWrite;
        end
        StWrite: begin
          if (wb.wb_ack || wb.wb_err) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            if (wb.wb_err) begin
              uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
              fail_adr_q   <= adr_q;
            end else begin
              corr_cnt_q <= sat_inc(corr_cnt_q);
            end
            state_q <= StNext;
          end
        end
        StNext: begin
          if (adr_q == LastAdr) begin
            adr_q       <= SCRUB_BASE;
            pass_done_q <= 1'b1;
          end else begin
            adr_q <= adr_q + 32'd4;
          end
          gap_q <= GapLoad;
          // Enable is only honoured between words so an open read/writeback always finishes.
          if (i_enable) begin
            state_q <= StGap;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb.wb_adr      = adr_q;
  assign wb.wb_sel      = sel_q;
  assign wb.wb_we       = we_q;
  assign wb.wb_dat_w    = dat_q;
  assign wb.wb_cyc      = cyc_q;
  assign wb.wb_stb      = stb_q;
  assign o_busy         = busy_q;
  assign o_corr_count   = corr_cnt_q;
  assign o_uncorr_count = uncorr_cnt_q;
  assign o_fail_adr     = fail_adr_q;
  assign o_pass_done    = pass_done_q;

endmodule

// File: tb/tb_edc_scrubber.sv
// Scoreboard bench for edc_scrubber: expected bus transactions are queued with their slave
// responses and checked as the scrubber issues them.
module tb_edc_scrubber;

  localparam logic [31:0] Base = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        busy;
  logic [15:0] corr;
  logic [15:0] uncorr;
  logic [31:0] fail_adr;
  logic        pass_done;

  edc_scrubber_if #(.WB_DWIDTH(32), .WB_SWIDTH(4)) bus ();

  edc_scrubber #(
    .WB_DWIDTH  (32),
    .WB_SWIDTH  (4),
    .SCRUB_BASE (Base),
    .SCRUB_WORDS(4),
    .IDLE_CYCLES(2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .wb            (bus),
    .o_busy        (busy),
    .o_corr_count  (corr),
    .o_uncorr_count(uncorr),
    .o_fail_adr    (fail_adr),
    .o_pass_done   (pass_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          gap;
    bit          single;
    bit          dbl;
    bit          err;
    logic [31:0] rdat;
    bit          stop;
    bit          rst_here;
  } txn_t;

  txn_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          low_cnt = 0;
  bit          in_txn  = 0;
  bit          pass_prev = 0;
  int          pass_cnt = 0;
  logic [15:0] exp_corr;
  logic [15:0] exp_uncorr;
  logic [31:0] exp_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input logic [31:0] adr, input int gap, input bit s, input bit d,
                         input bit e, input logic [31:0] rdat, input bit stop, input bit rh);
    txn_t t;
    t.we = 1'b0; t.adr = adr; t.dat = '0; t.gap = gap; t.single = s; t.dbl = d; t.err = e;
    t.rdat = rdat; t.stop = stop; t.rst_here = rh;
    sb.push_back(t);
  endtask

  task automatic push_wr(input logic [31:0] adr, input logic [31:0] dat, input bit e);
    txn_t t;
    t.we = 1'b1; t.adr = adr; t.dat = dat; t.gap = 1; t.single = 0; t.dbl = 0; t.err = e;
    t.rdat = '0; t.stop = 0; t.rst_here = 0;
    sb.push_back(t);
  endtask

  // Slave model and transaction checker, evaluated once per falling edge.
  task automatic slave_step();
    txn_t t;
    if (bus.wb_ack || bus.wb_err) begin
      bus.wb_ack = 0; bus.wb_err = 0; bus.edc_single = 0; bus.edc_double = 0; bus.wb_dat_r = '0;
    end
    if (pass_done) begin
      pass_cnt++;
      check_eq("pass_pulse_width", pass_prev, 0);
    end
    pass_prev = pass_done;
    if (bus.wb_stb !== 1'b1) begin
      low_cnt++;
      in_txn = 0;
    end else if (!in_txn) begin
      in_txn = 1;
      check_eq("sb_pending", sb.size() != 0, 1);
      if (sb.size() == 0) begin
        bus.wb_ack = 1;
      end else begin
        t = sb.pop_front();
        check_eq("txn_adr", bus.wb_adr, t.adr);
        check_eq("txn_we", bus.wb_we, t.we);
        check_eq("txn_cyc", bus.wb_cyc, 1);
        check_eq("txn_sel", bus.wb_sel, 4'hF);
        if (t.we) check_eq("txn_wdat", bus.wb_dat_w, t.dat);
        if (t.gap >= 0) check_eq("txn_stb_low_gap", low_cnt, t.gap);
        if (t.rst_here) begin
          rst = 1; enable = 0;
        end else if (t.err) begin
          bus.wb_err = 1;
        end else begin
          bus.wb_ack = 1; bus.edc_single = t.single; bus.edc_double = t.dbl;
          bus.wb_dat_r = t.rdat;
        end
        if (t.stop) enable = 0;
      end
      low_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic run_phase(input string tag, input int budget);
    int i;
    i = 0;
    pass_cnt = 0;
    enable = 1;
    while (i < budget && (sb.size() != 0 || busy !== 1'b0)) begin
      tick();
      i++;
    end
    check_eq({tag, "_done"}, (sb.size() == 0 && busy === 1'b0), 1);
  endtask

  task automatic check_state(input string tag, input int exp_pass);
    check_eq({tag, "_corr"}, corr, exp_corr);
    check_eq({tag, "_uncorr"}, uncorr, exp_uncorr);
    check_eq({tag, "_fail_adr"}, fail_adr, exp_fail);
    check_eq({tag, "_passes"}, pass_cnt, exp_pass);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_adr"}, bus.wb_adr, Base);
    check_eq({tag, "_cyc"}, bus.wb_cyc, 0);
    check_eq({tag, "_stb"}, bus.wb_stb, 0);
    check_eq({tag, "_we"}, bus.wb_we, 0);
    check_eq({tag, "_sel"}, bus.wb_sel, 0);
    check_eq({tag, "_wdat"}, bus.wb_dat_w, 0);
    check_eq({tag, "_corr"}, corr, 0);
    check_eq({tag, "_uncorr"}, uncorr, 0);
    check_eq({tag, "_fail_adr"}, fail_adr, 0);
    check_eq({tag, "_pass_done"}, pass_done, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1; enable = 0;
    bus.wb_ack = 0; bus.wb_err = 0; bus.edc_single = 0; bus.edc_double = 0; bus.wb_dat_r = '0;
    exp_corr = 0; exp_uncorr = 0; exp_fail = 0;
    repeat (3) tick();
    check_reset("reset");
    rst = 0;
    tick();

    // Clean pass: four reads, wrap to base, one pass_done.
    push_rd(32'h100, -1, 0, 0, 0, 32'h0, 0, 0);
    push_rd(32'h104, 4, 0, 0, 0, 32'h0, 0, 0);
    push_rd(32'h108, 4, 0, 0, 0, 32'h0, 0, 0);
    push_rd(32'h10C, 4, 0, 0, 0, 32'h0, 0, 0);
    push_rd(32'h100, 4, 0, 0, 0, 32'h0, 1, 0);
    run_phase("clean", 200);
    check_state("clean", 1);

    // Single error with enable dropped during the read: writeback still completes.
    push_rd(32'h104, -1, 1, 0, 0, 32'hDEADBEEF, 1, 0);
    push_wr(32'h104, 32'hDEADBEEF, 0);
    run_phase("single", 100);
    exp_corr = 1;
    check_state("single", 0);

    // Double beats single; writeback bus error counts as uncorrectable.
    push_rd(32'h108, -1, 1, 1, 0, 32'h0, 0, 0);
    push_rd(32'h10C, 4, 1, 0, 0, 32'h12345678, 0, 0);
    push_wr(32'h10C, 32'h12345678, 1);
    push_rd(32'h100, 4, 0, 0, 0, 32'h0, 1, 0);
    run_phase("dbl_werr", 200);
    exp_uncorr = 2; exp_fail = 32'h10C;
    check_state("dbl_werr", 1);

    // Bus error on a read.
    push_rd(32'h104, -1, 0, 0, 1, 32'h0, 0, 0);
    push_rd(32'h108, 4, 0, 0, 0, 32'h0, 1, 0);
    run_phase("rerr", 100);
    exp_uncorr = 3; exp_fail = 32'h104;
    check_state("rerr", 0);

    // Saturation: preload just below the top, then two more corrections.
    force dut.corr_cnt_q = 16'hFFFE;
    tick();
    release dut.corr_cnt_q;
    push_rd(32'h10C, -1, 1, 0, 0, 32'hA5A5A5A5, 0, 0);
    push_wr(32'h10C, 32'hA5A5A5A5, 0);
    push_rd(32'h100, 4, 1, 0, 0, 32'h0F0F0F0F, 1, 0);
    push_wr(32'h100, 32'h0F0F0F0F, 0);
    run_phase("sat", 200);
    exp_corr = 16'hFFFF;
    check_state("sat", 1);

    // Reset while a read is outstanding: strobe drops, no writeback, everything cleared.
    push_rd(32'h104, -1, 0, 0, 0, 32'h0, 0, 1);
    run_phase("rst_mid", 100);
    check_reset("rst_mid");
    rst = 0;
    tick();

    // After reset the walk restarts from the base address.
    push_rd(32'h100, -1, 0, 0, 0, 32'h0, 1, 0);
    run_phase("restart", 100);
    exp_corr = 0; exp_uncorr = 0; exp_fail = 0;
    check_state("restart", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
